// File: rtl/td4_branch_unit.sv
// TD4 branch unit: PC load decode (JMP/JNC/CALL/RET), carry flag and return-address stack.
// Optional feature macro: TD4_RET_STACK_EN builds the CALL/RET stack; undefined gives JMP/JNC only.
module td4_branch_unit #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic [3:0] imm,
    input  logic [3:0] pc,
    input  logic       carry_in,
    output logic       ld,
    output logic [3:0] load_addr,
    output logic       carry,
    output logic       stk_empty,
    output logic       stk_full,
    output logic       stk_err
);

    localparam logic [3:0] OP_JMP  = 4'b1111;
    localparam logic [3:0] OP_JNC  = 4'b1110;
    localparam logic [3:0] OP_CALL = 4'b1100;
    localparam logic [3:0] OP_RET  = 4'b1101;

    logic       carry_d;
    logic       carry_q;
    logic       ld_s;
    logic [3:0] load_addr_s;

`ifdef TD4_RET_STACK_EN
    localparam int PW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic [3:0]    stk_q [DEPTH];
    logic [3:0]    stk_d [DEPTH];
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          err_q;
    logic          err_d;
    logic [IW-1:0] top_idx_s;
    logic [IW-1:0] push_idx_s;
    logic          has_entry_s;
    logic          is_full_s;

    // ptr counts entries, so the top lives one below it; the low bits wrap correctly when full
    assign top_idx_s   = IW'(ptr_q - PW'(1));
    assign push_idx_s  = IW'(ptr_q);
    assign has_entry_s = (ptr_q != {PW{1'b0}});
    assign is_full_s   = (ptr_q == PW'(DEPTH));

    // Next-state for the return stack and its sticky error flag
    always_comb begin
        stk_d = stk_q;
        ptr_d = ptr_q;
        err_d = err_q;
        case (opcode)
            OP_CALL: begin
                if (!is_full_s) begin
                    stk_d[push_idx_s] = pc + 4'd1;
                    ptr_d             = ptr_q + PW'(1);
                end else begin
                    err_d = 1'b1;
                end
            end
            OP_RET: begin
                if (has_entry_s) begin
                    ptr_d = ptr_q - PW'(1);
                end else begin
                    err_d = 1'b1;
                end
            end
            default: begin
                ptr_d = ptr_q;
            end
        endcase
    end

    // Stack storage, pointer and error flag; reset drops every entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stk_q[i] <= 4'd0;
            end
            ptr_q <= {PW{1'b0}};
            err_q <= 1'b0;
        end else begin
            stk_q <= stk_d;
            ptr_q <= ptr_d;
            err_q <= err_d;
        end
    end

    assign stk_empty = !has_entry_s;
    assign stk_full  = is_full_s;
    assign stk_err   = err_q;
`else
    logic unused_s;

    assign unused_s  = (^pc) ^ (DEPTH > 0);
    assign stk_empty = 1'b1;
    assign stk_full  = 1'b0;
    assign stk_err   = 1'b0;
`endif

    // PC load decode; JNC looks only at the registered flag so carry_in never reaches ld
    always_comb begin
        ld_s        = 1'b1;
        load_addr_s = 4'd0;
        if (!reset) begin
            ld_s        = 1'b1;
            load_addr_s = 4'd0;
        end else begin
            case (opcode)
                OP_JMP: begin
                    ld_s        = 1'b0;
                    load_addr_s = imm;
                end
                OP_JNC: begin
                    if (!carry_q) begin
                        ld_s        = 1'b0;
                        load_addr_s = imm;
                    end else begin
                        ld_s        = 1'b1;
                        load_addr_s = 4'd0;
                    end
                end
`ifdef TD4_RET_STACK_EN
                OP_CALL: begin
                    ld_s        = 1'b0;
                    load_addr_s = imm;
                end
                OP_RET: begin
                    if (has_entry_s) begin
                        ld_s        = 1'b0;
                        load_addr_s = stk_q[top_idx_s];
                    end else begin
                        ld_s        = 1'b1;
                        load_addr_s = 4'd0;
                    end
                end
`endif
                default: begin
                    ld_s        = 1'b1;
                    load_addr_s = 4'd0;
                end
            endcase
        end
    end

    // Carry flag next state
    always_comb begin
        carry_d = carry_in;
    end

    // Carry flag register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

    assign ld        = ld_s;
    assign load_addr = load_addr_s;
    assign carry     = carry_q;

endmodule

// File: doc/td4_branch_unit.md
# td4_branch_unit

- Drives the program counter's load inputs (`ld`, active-low, and the 4-bit load address) from the instruction currently being executed.
- Decides JMP, JNC, CALL and RET targets.
- Holds the carry flag register and a small return-address stack.
- Sits between the instruction ROM/decoder and the program counter; one instruction executes per clock.

## Interface
Parameters:
- `DEPTH`, 4: return-stack entries; legal values 2, 4, 8.

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `opcode` in 4: upper nibble of the current instruction.
- `imm` in 4: lower nibble of the current instruction (jump/call target).
- `pc` in 4: current program counter value.
- `carry_in` in 1: adder carry-out of the current instruction.
- `ld` out 1: active-low PC load strobe (0 = load `load_addr`, 1 = increment).
- `load_addr` out 4: address the PC loads when `ld` = 0.
- `carry` out 1: registered carry flag.
- `stk_empty` out 1: return stack holds no entries.
- `stk_full` out 1: return stack holds `DEPTH` entries.
- `stk_err` out 1: sticky flag; set on stack overflow or underflow.

## Operation
Opcode decode; `ld`/`load_addr` are combinational from `opcode`, `imm`, `carry` and the top of stack.
- 1111 JMP: `ld`=0, `load_addr`=`imm`.
- 1110 JNC: if `carry`=0, `ld`=0 and `load_addr`=`imm`; otherwise `ld`=1.
- 1100 CALL: `ld`=0, `load_addr`=`imm`; push (`pc`+1) mod 16 at the clock edge.
- 1101 RET: if the stack is non-empty, `ld`=0, `load_addr`=top of stack, pop at the clock edge.
- All other opcodes: `ld`=1, `load_addr`=0.

Carry flag:
- Every clock, `carry` <= `carry_in`.
- JNC tests the flag captured from the previous instruction, never the current `carry_in`.

Stack:
- LIFO of `DEPTH` × 4-bit entries.
- Pointer range 0..`DEPTH`; `stk_empty` = (ptr==0); `stk_full` = (ptr==`DEPTH`).
- Return address wraps: CALL at `pc`=15 pushes 0.

Boundary conditions:
- CALL when full: jump still taken, push dropped, ptr unchanged, `stk_err`<=1.
- RET when empty: `ld`=1 (PC increments), ptr unchanged, `stk_err`<=1.
- `stk_err` clears only on reset.
- CALL and RET are never simultaneous; one opcode per cycle.

## Timing
- Reset (`reset`=0, asynchronous):
  - `carry`=0, ptr=0, `stk_empty`=1, `stk_full`=0, `stk_err`=0.
  - `ld` forced to 1 and `load_addr` to 0 while `reset`=0, regardless of inputs.
- Reset mid-operation discards all stack contents immediately; entries are not preserved.
- `ld`/`load_addr`: zero-cycle latency from `opcode`/`imm`, valid before the same rising edge at which the PC samples them.
- Stack push/pop, `carry`, and `stk_err` update at that same edge; new values are visible in the next cycle.
- No combinational path from `carry_in` to `ld`.

## Configuration
- `TD4_RET_STACK_EN` defined:
  - CALL/RET and the stack are implemented as above.
- `TD4_RET_STACK_EN` undefined:
  - No stack storage is built.
  - 1100/1101 decode as NOP (`ld`=1).
  - `stk_empty`=1, `stk_full`=0, `stk_err`=0 constantly.
  - JMP/JNC/carry behaviour is unchanged.

## Test plan
- Reset: assert `reset`=0 with `opcode`=1111 `imm`=0101 -> `ld`=1, `load_addr`=0, `carry`=0, `stk_empty`=1; release -> `ld`=0, `load_addr`=0101.
- JNC: cycle n `carry_in`=1, cycle n+1 JNC `imm`=0011 -> `ld`=1; repeat with `carry_in`=0 -> `ld`=0, `load_addr`=0011.
- CALL/RET: `pc`=0110, CALL `imm`=1010 -> `ld`=0, `load_addr`=1010; next cycle RET -> `ld`=0, `load_addr`=0111, `stk_empty`=1.
- Wrap: CALL at `pc`=1111 then RET -> `load_addr`=0000.
- Overflow: 4 CALLs with `DEPTH`=4 -> `stk_full`=1; 5th CALL -> jump taken, `stk_err`=1; 4 RETs return the first four addresses in LIFO order.
- Underflow and macro off: RET when empty -> `ld`=1, `stk_err`=1. With `TD4_RET_STACK_EN` undefined, CALL `imm`=1010 -> `ld`=1, `stk_empty`=1.
